uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   Serial UART transmitter. Sits between a byte-stream producer (MMIO UART
//   register block or TX FIFO) and the tx pin. Frames each byte per
//   uart_common::uart_config_t: start bit, 7/8 data bits (LSB first),
//   optional parity, 1/2 stop bits. Honours RTS/CTS, DSR/DTR and XON/XOFF
//   gating at frame boundaries.
// PARAMETERS
//   (none; all frame format comes from cfg_i at run time)
// PORTS
//   clk_i      in   1   system clock
//   reset_ni   in   1   asynchronous, active-low reset
//   cfg_i      in   34  uart_config_t; sampled only at frame start
//   data_i     in   8   byte to send; bit 7 ignored when data_bits = DATA_SEVEN
//   valid_i    in   1   data_i valid
//   ready_o    out  1   transmitter accepts data_i this cycle
//   cts_i      in   1   1 = peer clear to send (FLOW_RTS_CTS)
//   dsr_i      in   1   1 = peer data set ready (FLOW_DSR_DTR)
//   xoff_i     in   1   1 = XOFF received, from the RX side (FLOW_XON_XOFF)
//   tx_o       out  1   serial line, idle high
//   busy_o     out  1   frame in progress (state != IDLE)
// BEHAVIOUR
//   Reset values: tx_o=1, ready_o=0, busy_o=0, state=IDLE, counters=0.
//   Reset is asynchronous and may assert mid-frame. tx_o returns to 1
//   immediately and the partial frame is discarded.
//   Bit period: P = cfg.samples_per_bit clocks. P=0 is treated as P=1.
//   go = flow_control==NONE | (RTS_CTS & cts_i) | (DSR_DTR & dsr_i)
//        | (XON_XOFF & ~xoff_i).
//   ready_o = (state==IDLE) & go (combinational).
//   Handshake: transfer on valid_i & ready_o at a rising edge.
//   At that edge: latch data_i and cfg_i into shadow registers, and go to START.
//   tx_o is driven from a register. tx_o=0 from the first cycle after the transfer.
//   FSM (each non-IDLE state lasts exactly P cycles, via a 24-bit down-counter):
//     IDLE   tx=1. Transfer -> START.
//     START  tx=0 -> DATA, bit index 0.
//     DATA   tx=shadow_data[idx]. After 7 (SEVEN) or 8 (EIGHT) bits:
//            -> PARITY if parity[2]==1, else -> STOP1.
//     PARITY tx = EVEN: ^sent_bits; ODD: ~^sent_bits; MARK: 1; SPACE: 0
//            -> STOP1.
//     STOP1  tx=1 -> STOP2 if stop_bits==STOP_TWO, else -> IDLE.
//     STOP2  tx=1 -> IDLE.
//   Parity codes with bit2=0 (incl. reserved 001..011) mean no parity.
//   sent_bits covers only the transmitted data bits: 7 or 8.
//   Flow-control gating is checked only in IDLE. A frame in flight always
//   completes even if cts_i/dsr_i drop or xoff_i rises.
//   cfg_i changes during a frame have no effect until the next frame.
//   Back-to-back: valid_i held high gives exactly one IDLE cycle (tx=1)
//   between the last stop bit and the next start bit.
//   Frame length = P*(1+N+par+S) + 1 idle clocks, where N=7|8, par=0|1, S=1|2.
//   Reserved field of cfg_i is ignored.
// TESTING
//   8N1, P=4, send 0x55 -> tx_o = 0,1,0,1,0,1,0,1,0,1, each held 4 clk.
//     busy_o high for 40 clk, then ready_o=1.
//   7E1, P=2, send 0xC1 -> data 1,0,0,0,0,0,1 (bit7 dropped), parity 0,
//     stop 1. Frame = 20 clk.
//   8O2, P=3, send 0x00 -> 8 zeros, parity 1, two stop bits. Frame = 36 clk.
//   RTS/CTS, cts_i=0, valid_i=1 -> ready_o=0, tx_o=1 for 50 clk.
//     Raise cts_i -> transfer next edge. Drop cts_i mid-frame -> frame still
//     completes bit-exact.
//   8N1, P=1, valid_i held, bytes 0xA5 then 0x3C -> 10-bit frames
//     separated by exactly one idle clk. Both bytes decode correctly.
//   P=0 -> same waveform as P=1. Assert reset_ni=0 in DATA bit 3 ->
//     tx_o=1, busy_o=0 same cycle. After release, a new frame starts cleanly.

Source files
------------

// File: rtl/uart_tx.sv
// Frame-format types shared by the UART transmitter and its producers.
package uart_common;
    localparam logic       DATA_SEVEN    = 1'b0;
    localparam logic       DATA_EIGHT    = 1'b1;
    localparam logic [2:0] PAR_NONE      = 3'b000;
    localparam logic [2:0] PAR_EVEN      = 3'b100;
    localparam logic [2:0] PAR_ODD       = 3'b101;
    localparam logic [2:0] PAR_MARK      = 3'b110;
    localparam logic [2:0] PAR_SPACE     = 3'b111;
    localparam logic       STOP_ONE      = 1'b0;
    localparam logic       STOP_TWO      = 1'b1;
    localparam logic [1:0] FLOW_NONE     = 2'd0;
    localparam logic [1:0] FLOW_RTS_CTS  = 2'd1;
    localparam logic [1:0] FLOW_DSR_DTR  = 2'd2;
    localparam logic [1:0] FLOW_XON_XOFF = 2'd3;

    typedef struct packed {
        logic [2:0]  reserved;
        logic [1:0]  flow_control;
        logic        stop_bits;
        logic [2:0]  parity;
        logic        data_bits;
        logic [23:0] samples_per_bit;
    } uart_config_t;
endpackage

// Serial UART transmitter: start, 7/8 data bits LSB first, optional parity, 1/2 stop bits.
// Flow control gates only the start of a frame; a frame in flight always completes.
module uart_tx
    import uart_common::*;
(
    input  logic         clk_i,
    input  logic         reset_ni,
    input  uart_config_t cfg_i,
    input  logic [7:0]   data_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         cts_i,
    input  logic         dsr_i,
    input  logic         xoff_i,
    output logic         tx_o,
    output logic         busy_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_e;

    state_e      r_state, w_state_nxt;
    logic [23:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic        r_tx, w_tx_nxt;
    logic        r_run;
    logic [7:0]  r_data;
    logic [23:0] r_per_m1;
    logic        r_eight;
    logic [2:0]  r_parity;
    logic        r_two;

    logic        w_go;
    logic        w_xfer;
    logic        w_par_bit;
    logic [2:0]  w_last_idx;
    logic [23:0] w_per_in_m1;
    logic        w_unused;

    assign w_unused = ^cfg_i.reserved;

    assign w_go = (cfg_i.flow_control == FLOW_NONE)
                | ((cfg_i.flow_control == FLOW_RTS_CTS)  & cts_i)
                | ((cfg_i.flow_control == FLOW_DSR_DTR)  & dsr_i)
                | ((cfg_i.flow_control == FLOW_XON_XOFF) & ~xoff_i);

    // r_run keeps ready_o low while reset is held and on the first cycle after.
    assign ready_o = r_run & (r_state == S_IDLE) & w_go;
    assign w_xfer  = valid_i & ready_o;
    assign busy_o  = (r_state != S_IDLE);
    assign tx_o    = r_tx;

    assign w_per_in_m1 = (cfg_i.samples_per_bit == 24'd0) ? 24'd0
                                                          : cfg_i.samples_per_bit - 24'd1;
    assign w_last_idx  = r_eight ? 3'd7 : 3'd6;

    // r_data has bit 7 cleared for 7-bit frames, so XOR over all 8 bits is correct.
    always_comb begin
        case (r_parity[1:0])
            2'b00:   w_par_bit = ^r_data;
            2'b01:   w_par_bit = ~^r_data;
            2'b10:   w_par_bit = 1'b1;
            default: w_par_bit = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_tx_nxt    = r_tx;
        if (r_state == S_IDLE) begin
            w_tx_nxt = 1'b1;
            if (w_xfer) begin
                w_state_nxt = S_START;
                w_cnt_nxt   = w_per_in_m1;
                w_tx_nxt    = 1'b0;
            end
        end else if (r_cnt != 24'd0) begin
            w_cnt_nxt = r_cnt - 24'd1;
        end else begin
            w_cnt_nxt = r_per_m1;
            case (r_state)
                S_START: begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = 3'd0;
                    w_tx_nxt    = r_data[0];
                end
                S_DATA: begin
                    if (r_idx == w_last_idx) begin
                        if (r_parity[2]) begin
                            w_state_nxt = S_PARITY;
                            w_tx_nxt    = w_par_bit;
                        end else begin
                            w_state_nxt = S_STOP1;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                        w_tx_nxt  = r_data[r_idx + 3'd1];
                    end
                end
                S_PARITY: begin
                    w_state_nxt = S_STOP1;
                    w_tx_nxt    = 1'b1;
                end
                S_STOP1: begin
                    w_tx_nxt = 1'b1;
                    if (r_two) begin
                        w_state_nxt = S_STOP2;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 24'd0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 24'd0;
                    w_tx_nxt    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= 24'd0;
            r_idx   <= 3'd0;
            r_tx    <= 1'b1;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            r_run   <= 1'b1;
        end
    end

    // Shadow copy of byte and format, so cfg_i may change freely mid-frame.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_data   <= 8'd0;
            r_per_m1 <= 24'd0;
            r_eight  <= 1'b0;
            r_parity <= 3'd0;
            r_two    <= 1'b0;
        end else if (w_xfer) begin
            r_data   <= (cfg_i.data_bits == DATA_EIGHT) ? data_i : {1'b0, data_i[6:0]};
            r_per_m1 <= w_per_in_m1;
            r_eight  <= (cfg_i.data_bits == DATA_EIGHT);
            r_parity <= cfg_i.parity;
            r_two    <= (cfg_i.stop_bits == STOP_TWO);
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle tx/busy/ready compared against a queue of expected line levels.
module tb_uart_tx;
    import uart_common::*;

    logic         clk_i = 1'b0;
    logic         reset_ni;
    uart_config_t cfg_i;
    logic [7:0]   data_i;
    logic         valid_i;
    logic         ready_o;
    logic         cts_i, dsr_i, xoff_i;
    logic         tx_o;
    logic         busy_o;

    uart_tx dut (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .cfg_i   (cfg_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .cts_i   (cts_i),
        .dsr_i   (dsr_i),
        .xoff_i  (xoff_i),
        .tx_o    (tx_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];
    bit xfer;
    int run_len, idle_len, last_len, gap_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic uart_config_t mk(input int p, input logic eight, input logic [2:0] par,
                                        input logic two, input logic [1:0] flow);
        uart_config_t c;
        c = '0;
        c.samples_per_bit = p[23:0];
        c.data_bits       = eight;
        c.parity          = par;
        c.stop_bits       = two;
        c.flow_control    = flow;
        return c;
    endfunction

    function automatic bit go_m(input uart_config_t c, input logic cts, input logic dsr,
                                input logic xoff);
        case (c.flow_control)
            FLOW_NONE:    return 1'b1;
            FLOW_RTS_CTS: return cts;
            FLOW_DSR_DTR: return dsr;
            default:      return !xoff;
        endcase
    endfunction

    // Expected line level for every clock of one frame.
    function automatic void push_frame(input uart_config_t c, input logic [7:0] d);
        int p, nb, ones;
        bit bits[$];
        p    = (c.samples_per_bit == 0) ? 1 : int'(c.samples_per_bit);
        nb   = (c.data_bits == DATA_EIGHT) ? 8 : 7;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (c.parity[2]) begin
            case (c.parity[1:0])
                2'b00:   bits.push_back(ones % 2 == 1);
                2'b01:   bits.push_back(ones % 2 == 0);
                2'b10:   bits.push_back(1'b1);
                default: bits.push_back(1'b0);
            endcase
        end
        bits.push_back(1'b1);
        if (c.stop_bits == STOP_TWO) bits.push_back(1'b1);
        foreach (bits[k])
            for (int j = 0; j < p; j++) exp_q.push_back(bits[k]);
    endfunction

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic cycle();
        bit e_tx, e_busy, e_rdy;
        #1;
        if (exp_q.size() > 0) begin
            e_tx   = exp_q.pop_front();
            e_busy = 1'b1;
        end else begin
            e_tx   = 1'b1;
            e_busy = 1'b0;
        end
        e_rdy = !e_busy && go_m(cfg_i, cts_i, dsr_i, xoff_i);
        chk("tx", tx_o, e_tx);
        chk("busy", busy_o, e_busy);
        chk("ready", ready_o, e_rdy);
        if (busy_o) begin
            if (run_len == 0) gap_last = idle_len;
            run_len++;
            idle_len = 0;
        end else begin
            if (run_len > 0) last_len = run_len;
            run_len = 0;
            idle_len++;
        end
        if (valid_i && e_rdy) begin
            push_frame(cfg_i, data_i);
            xfer = 1'b1;
        end
        @(negedge clk_i);
    endtask

    task automatic drain();
        valid_i = 1'b0;
        while (exp_q.size() > 0) cycle();
        cycle();
        cycle();
    endtask

    task automatic send(input uart_config_t c, input logic [7:0] d);
        logic [63:0] r;
        cfg_i   = c;
        data_i  = d;
        valid_i = 1'b1;
        xfer    = 1'b0;
        for (int i = 0; i < 200 && !xfer; i++) cycle();
        if (!xfer) chk("xfer_timeout", 0, 1);
        valid_i = 1'b0;
        r = {$urandom, $urandom};
        cfg_i = r[33:0];
        cfg_i.flow_control = FLOW_NONE;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        exp_q.delete();
        run_len  = 0;
        idle_len = 0;
        #1;
        chk("rst_tx", tx_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", ready_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_hold_tx", tx_o, 1);
        chk("rst_hold_ready", ready_o, 0);
        reset_ni = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        logic [63:0] r;
        int flen;
        reset_ni = 1'b0;
        cfg_i    = mk(4, DATA_EIGHT, PAR_NONE, STOP_ONE, FLOW_NONE);
        data_i   = 8'h00;
        valid_i  = 1'b1;
        cts_i    = 1'b0;
        dsr_i    = 1'b0;
        xoff_i   = 1'b0;
        run_len  = 0;
        idle_len = 0;
        last_len = 0;
        gap_last = 0;
        @(negedge clk_i);
        do_reset();
        valid_i = 1'b0;

        send(mk(4, DATA_EIGHT, PAR_NONE, STOP_ONE, FLOW_NONE), 8'h55);
        drain();
        chk("len_8n1_p4", last_len, 40);

        send(mk(2, DATA_SEVEN, PAR_EVEN, STOP_ONE, FLOW_NONE), 8'hC1);
        drain();
        chk("len_7e1_p2", last_len, 20);

        send(mk(3, DATA_EIGHT, PAR_ODD, STOP_TWO, FLOW_NONE), 8'h00);
        drain();
        chk("len_8o2_p3", last_len, 36);

        // CTS held low blocks the start; dropping it mid-frame must not.
        cfg_i   = mk(2, DATA_EIGHT, PAR_MARK, STOP_ONE, FLOW_RTS_CTS);
        data_i  = 8'h96;
        valid_i = 1'b1;
        cts_i   = 1'b0;
        xfer    = 1'b0;
        repeat (50) cycle();
        chk("cts_blocked", xfer, 0);
        cts_i = 1'b1;
        cycle();
        chk("cts_xfer", xfer, 1);
        valid_i = 1'b0;
        repeat (6) cycle();
        cts_i = 1'b0;
        drain();
        chk("len_cts_frame", last_len, 22);

        // Back-to-back with valid held.
        cfg_i   = mk(1, DATA_EIGHT, PAR_NONE, STOP_ONE, FLOW_NONE);
        data_i  = 8'hA5;
        valid_i = 1'b1;
        xfer    = 1'b0;
        for (int i = 0; i < 20 && !xfer; i++) cycle();
        data_i = 8'h3C;
        xfer   = 1'b0;
        for (int i = 0; i < 40 && !xfer; i++) cycle();
        chk("b2b_second_xfer", xfer, 1);
        valid_i = 1'b0;
        drain();
        chk("b2b_gap", gap_last, 1);
        chk("b2b_len", last_len, 10);

        send(mk(0, DATA_EIGHT, PAR_NONE, STOP_ONE, FLOW_NONE), 8'h6B);
        drain();
        chk("len_p0", last_len, 10);

        // Reset asserted during data bit 3.
        send(mk(2, DATA_EIGHT, PAR_NONE, STOP_ONE, FLOW_NONE), 8'hF0);
        flen = exp_q.size();
        while (exp_q.size() > flen - 9) cycle();
        #2;
        chk("pre_rst_busy", busy_o, 1);
        do_reset();
        send(mk(2, DATA_EIGHT, PAR_EVEN, STOP_TWO, FLOW_NONE), 8'h3D);
        drain();
        chk("len_after_rst", last_len, 24);

        // Randomized traffic: format, flow state and cfg_i all change freely.
        for (int i = 0; i < 3000; i++) begin
            r = {$urandom, $urandom};
            cfg_i = r[33:0];
            cfg_i.samples_per_bit = 24'($urandom_range(0, 3));
            data_i  = 8'($urandom);
            valid_i = ($urandom_range(0, 3) != 0);
            if (i % 8 == 0) begin
                cts_i  = 1'($urandom);
                dsr_i  = 1'($urandom);
                xoff_i = 1'($urandom);
            end
            cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
